pipeline_stall_ctrl: RTL and testbench

PIPELINE_STALL_CTRL -- requirements
Module: pipeline_stall_ctrl

---
 rtl/pipeline_stall_ctrl.sv | 142 ++++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall/flush controller: load-use stalls, branch flushes, data-memory freeze with timeout fault.
// Optional stall performance counter built only when STALL_PERF_CNT_EN is defined.
module pipeline_stall_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_use_i,
  input  logic             branch_taken_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ack_i,
  output logic             pc_en_o,
  output logic             ifid_en_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             exmem_en_o,
  output logic             memwb_bubble_o,
  output logic             fault_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FAULT    = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  state_t     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       fault_q, fault_d;
  logic       freeze;
  logic       hazard_eval;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= RUN;
      wait_q  <= 8'd0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      fault_q <= fault_d;
    end
  end

  // Next state plus zero-latency outputs; reset masks every request so the pipeline free-runs.
  always_comb begin
    state_d        = state_q;
    wait_d         = wait_q;
    fault_d        = fault_q;
    freeze         = 1'b0;
    hazard_eval    = 1'b0;
    pc_en_o        = 1'b1;
    ifid_en_o      = 1'b1;
    ifid_flush_o   = 1'b0;
    idex_bubble_o  = 1'b0;
    exmem_en_o     = 1'b1;
    memwb_bubble_o = 1'b0;

    if (!rst_i) begin
      state_d = RUN;
      wait_d  = 8'd0;
      fault_d = 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (dmem_req_i && !dmem_ack_i) begin
            freeze  = 1'b1;
            state_d = MEM_WAIT;
            wait_d  = 8'd1;
          end else begin
            hazard_eval = 1'b1;
            wait_d      = 8'd0;
          end
        end
        MEM_WAIT: begin
          if (dmem_ack_i) begin
            hazard_eval = 1'b1;
            state_d     = RUN;
            wait_d      = 8'd0;
          end else begin
            freeze = 1'b1;
            // Counter saturates at the timeout so it can never wrap back below it.
            if (wait_q < TIMEOUT) begin
              wait_d = wait_q + 8'd1;
            end
            if (wait_q >= TIMEOUT) begin
              state_d = FAULT;
              fault_d = 1'b1;
            end
          end
        end
        FAULT: begin
          freeze  = 1'b1;
          fault_d = 1'b1;
        end
        default: begin
          state_d = RUN;
          wait_d  = 8'd0;
        end
      endcase
    end

    if (freeze) begin
      pc_en_o        = 1'b0;
      ifid_en_o      = 1'b0;
      exmem_en_o     = 1'b0;
      memwb_bubble_o = 1'b1;
    end else if (hazard_eval) begin
      if (load_use_i) begin
        pc_en_o       = 1'b0;
        ifid_en_o     = 1'b0;
        idex_bubble_o = 1'b1;
      end else if (branch_taken_i) begin
        ifid_flush_o = 1'b1;
      end
    end
  end

  assign fault_o = fault_q;

`ifdef STALL_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q;

  // Counts cycles where the PC is held; saturates instead of wrapping.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      stall_q <= '0;
    end else if (!pc_en_o && (stall_q != {CNT_W{1'b1}})) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed self-checking bench for pipeline_stall_ctrl (MEM_TIMEOUT=4, CNT_W=4).
module tb_pipeline_stall_ctrl;

  logic       clk;
  logic       rst;
  logic       ld;
  logic       br;
  logic       req;
  logic       ack;
  logic       pc_en, ifid_en, ifid_flush, idex_bubble, exmem_en, memwb_bubble;
  logic       fault;
  logic [3:0] cnt;
  logic [5:0] ctl;

  int checks = 0;
  int errors = 0;
  int exp_stalls = 0;

  // {pc_en, ifid_en, ifid_flush, idex_bubble, exmem_en, memwb_bubble}
  localparam logic [5:0] RUNV = 6'b110010;
  localparam logic [5:0] FRZ  = 6'b000001;
  localparam logic [5:0] LDU  = 6'b000110;
  localparam logic [5:0] BRF  = 6'b111010;

  assign ctl = {pc_en, ifid_en, ifid_flush, idex_bubble, exmem_en, memwb_bubble};

  pipeline_stall_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .load_use_i     (ld),
    .branch_taken_i (br),
    .dmem_req_i     (req),
    .dmem_ack_i     (ack),
    .pc_en_o        (pc_en),
    .ifid_en_o      (ifid_en),
    .ifid_flush_o   (ifid_flush),
    .idex_bubble_o  (idex_bubble),
    .exmem_en_o     (exmem_en),
    .memwb_bubble_o (memwb_bubble),
    .fault_o        (fault),
    .stall_cnt_o    (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] exp_cnt(input int n);
`ifdef STALL_PERF_CNT_EN
    return (n > 15) ? 4'd15 : 4'(n);
`else
    return 4'd0;
`endif
  endfunction

  task automatic drive(input logic r, input logic l, input logic b, input logic q, input logic a);
    rst = r; ld = l; br = b; req = q; ack = a;
    #1;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    checks++; if (ctl !== RUNV) begin errors++; $display("[TB] FAIL reset_mask: got %b expected %b", ctl, RUNV); end
    tick(); exp_stalls = 0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (ctl !== RUNV) begin errors++; $display("[TB] FAIL reset_idle: got %b expected %b", ctl, RUNV); end
    checks++; if (fault !== 1'b0) begin errors++; $display("[TB] FAIL reset_fault: got %b expected 0", fault); end
    checks++; if (cnt !== exp_cnt(0)) begin errors++; $display("[TB] FAIL reset_cnt: got %0d expected %0d", cnt, exp_cnt(0)); end
    tick();
  endtask

  task automatic test_load_use();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (ctl !== LDU) begin errors++; $display("[TB] FAIL load_use: got %b expected %b", ctl, LDU); end
    tick(); exp_stalls++;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (ctl !== RUNV) begin errors++; $display("[TB] FAIL load_use_release: got %b expected %b", ctl, RUNV); end
    checks++; if (cnt !== exp_cnt(exp_stalls)) begin errors++; $display("[TB] FAIL load_use_cnt: got %0d expected %0d", cnt, exp_cnt(exp_stalls)); end
    tick();
  endtask

  task automatic test_priority();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    checks++; if (ctl !== LDU) begin errors++; $display("[TB] FAIL ld_over_branch: got %b expected %b", ctl, LDU); end
    tick(); exp_stalls++;
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (ctl !== BRF) begin errors++; $display("[TB] FAIL branch_flush: got %b expected %b", ctl, BRF); end
    tick();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    checks++; if (ctl !== LDU) begin errors++; $display("[TB] FAIL hit_with_load_use: got %b expected %b", ctl, LDU); end
    tick(); exp_stalls++;
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    checks++; if (ctl !== BRF) begin errors++; $display("[TB] FAIL hit_with_branch: got %b expected %b", ctl, BRF); end
    tick();
  endtask

  task automatic test_mem_wait();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    checks++; if (ctl !== FRZ) begin errors++; $display("[TB] FAIL miss_freeze: got %b expected %b", ctl, FRZ); end
    tick(); exp_stalls++;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    checks++; if (ctl !== FRZ) begin errors++; $display("[TB] FAIL wait1_freeze: got %b expected %b", ctl, FRZ); end
    tick(); exp_stalls++;
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    checks++; if (ctl !== FRZ) begin errors++; $display("[TB] FAIL wait2_freeze: got %b expected %b", ctl, FRZ); end
    tick(); exp_stalls++;
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    checks++; if (ctl !== BRF) begin errors++; $display("[TB] FAIL ack_release: got %b expected %b", ctl, BRF); end
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (ctl !== RUNV) begin errors++; $display("[TB] FAIL back_in_run: got %b expected %b", ctl, RUNV); end
    checks++; if (fault !== 1'b0) begin errors++; $display("[TB] FAIL mem_wait_fault: got %b expected 0", fault); end
    checks++; if (cnt !== exp_cnt(exp_stalls)) begin errors++; $display("[TB] FAIL mem_wait_cnt: got %0d expected %0d", cnt, exp_cnt(exp_stalls)); end
    tick();
  endtask

  task automatic test_timeout();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++; if (ctl !== FRZ) begin errors++; $display("[TB] FAIL timeout_miss: got %b expected %b", ctl, FRZ); end
    tick(); exp_stalls++;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      checks++; if (ctl !== FRZ) begin errors++; $display("[TB] FAIL timeout_wait%0d: got %b expected %b", i, ctl, FRZ); end
      checks++; if (fault !== 1'b0) begin errors++; $display("[TB] FAIL timeout_early_fault%0d: got %b expected 0", i, fault); end
      tick(); exp_stalls++;
    end
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    checks++; if (ctl !== FRZ) begin errors++; $display("[TB] FAIL fault_freeze: got %b expected %b", ctl, FRZ); end
    checks++; if (fault !== 1'b1) begin errors++; $display("[TB] FAIL fault_set: got %b expected 1", fault); end
    tick(); exp_stalls++;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      tick(); exp_stalls++;
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (ctl !== FRZ) begin errors++; $display("[TB] FAIL fault_held: got %b expected %b", ctl, FRZ); end
    checks++; if (fault !== 1'b1) begin errors++; $display("[TB] FAIL fault_sticky: got %b expected 1", fault); end
    checks++; if (cnt !== exp_cnt(exp_stalls)) begin errors++; $display("[TB] FAIL cnt_saturate: got %0d expected %0d", cnt, exp_cnt(exp_stalls)); end
    tick(); exp_stalls++;
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    checks++; if (ctl !== RUNV) begin errors++; $display("[TB] FAIL fault_reset_mask: got %b expected %b", ctl, RUNV); end
    tick(); exp_stalls = 0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (ctl !== RUNV) begin errors++; $display("[TB] FAIL fault_reset_run: got %b expected %b", ctl, RUNV); end
    checks++; if (fault !== 1'b0) begin errors++; $display("[TB] FAIL fault_cleared: got %b expected 0", fault); end
    checks++; if (cnt !== 4'd0) begin errors++; $display("[TB] FAIL fault_reset_cnt: got %0d expected 0", cnt); end
    tick();
  endtask

  task automatic test_reset_in_wait();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(); exp_stalls++;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++; if (ctl !== FRZ) begin errors++; $display("[TB] FAIL wait_before_reset: got %b expected %b", ctl, FRZ); end
    tick(); exp_stalls++;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++; if (ctl !== RUNV) begin errors++; $display("[TB] FAIL wait_reset_mask: got %b expected %b", ctl, RUNV); end
    tick(); exp_stalls = 0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (ctl !== RUNV) begin errors++; $display("[TB] FAIL after_wait_reset: got %b expected %b", ctl, RUNV); end
    checks++; if (cnt !== 4'd0) begin errors++; $display("[TB] FAIL wait_reset_cnt: got %0d expected 0", cnt); end
    checks++; if (fault !== 1'b0) begin errors++; $display("[TB] FAIL wait_reset_fault: got %b expected 0", fault); end
    tick();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      checks++; if (ctl !== LDU) begin errors++; $display("[TB] FAIL b2b_load_use%0d: got %b expected %b", i, ctl, LDU); end
      tick(); exp_stalls++;
    end
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++; if (ctl !== FRZ) begin errors++; $display("[TB] FAIL b2b_miss: got %b expected %b", ctl, FRZ); end
    tick(); exp_stalls++;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    checks++; if (ctl !== LDU) begin errors++; $display("[TB] FAIL release_load_use: got %b expected %b", ctl, LDU); end
    tick(); exp_stalls++;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (ctl !== RUNV) begin errors++; $display("[TB] FAIL b2b_idle: got %b expected %b", ctl, RUNV); end
    checks++; if (cnt !== exp_cnt(exp_stalls)) begin errors++; $display("[TB] FAIL b2b_cnt: got %0d expected %0d", cnt, exp_cnt(exp_stalls)); end
    tick();
  endtask

  initial begin
    rst = 1'b0; ld = 1'b0; br = 1'b0; req = 1'b0; ack = 1'b0;
    test_reset();
    test_load_use();
    test_priority();
    test_mem_wait();
    test_timeout();
    test_reset_in_wait();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
